// File: rtl/muldiv_sequencer_if.sv
// Core-side handshake and operand bus for the RV32M multiply/divide sequencer.
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
   logic             start;
   logic             flush;
   logic [2:0]       funct3;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             busy;
   logic             stall;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (output start, flush, funct3, op_a, op_b,
                   input  busy, stall, done, result);
   modport slave  (input  start, flush, funct3, op_a, op_b,
                   output busy, stall, done, result);
endinterface

// File: rtl/muldiv_sequencer.sv
// Radix-2 multi-cycle RV32M multiply/divide sequencer (shift-add / restoring divide).
// Optional build macro MULDIV_FASTPATH_EN: trivial operands skip the iteration phase.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one radix-2 iteration per clock, counter counts down
// FIX   | sign correction, special-case override, result register load
// DONE  | done pulse, back to IDLE
module muldiv_sequencer #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input logic             clk,
   input logic             rst_n,
   muldiv_sequencer_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       f3;
   logic             sign_a, sign_b, b_zero;
   logic [WIDTH-1:0] hi, lo, bmag, result;

   logic             accept;
   logic             in_div, in_sa, in_sb, neg_a_in, neg_b_in;
   logic [WIDTH-1:0] a_mag_in, b_mag_in;

   assign accept   = (state == IDLE) & bus.start & ~bus.flush;
   assign in_div   = bus.funct3[2];
   assign in_sa    = in_div ? ~bus.funct3[0] : (bus.funct3[1:0] == 2'b01 || bus.funct3[1:0] == 2'b10);
   assign in_sb    = in_div ? ~bus.funct3[0] : (bus.funct3[1:0] == 2'b01);
   assign neg_a_in = in_sa & bus.op_a[WIDTH-1];
   assign neg_b_in = in_sb & bus.op_b[WIDTH-1];
   assign a_mag_in = neg_a_in ? ({WIDTH{1'b0}} - bus.op_a) : bus.op_a;
   assign b_mag_in = neg_b_in ? ({WIDTH{1'b0}} - bus.op_b) : bus.op_b;

`ifdef MULDIV_FASTPATH_EN
   // Preloaded hi/lo are the unsigned-domain answer, so FIX handles them like a real run.
   logic             in_bzero, in_ovf, trivial;
   logic [WIDTH-1:0] triv_hi, triv_lo;
   assign in_bzero = (bus.op_b == '0);
   assign in_ovf   = in_div & ~bus.funct3[0] & (bus.op_a == {1'b1, {(WIDTH-1){1'b0}}}) & (bus.op_b == '1);
   assign trivial  = in_div ? (in_bzero | in_ovf) : ((bus.op_a == '0) | in_bzero);
   assign triv_hi  = (in_div & in_bzero) ? a_mag_in : '0;
   assign triv_lo  = in_div ? (in_bzero ? '1 : a_mag_in) : '0;
`endif

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic             div_ge;
   logic [WIDTH-1:0] div_sub;

   assign mul_sum   = {1'b0, hi} + {1'b0, bmag};
   assign div_shift = {hi, lo[WIDTH-1]};
   assign div_ge    = div_shift >= {1'b0, bmag};
   assign div_sub   = div_shift[WIDTH-1:0] - bmag;

   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   quo_s, rem_s, fix_val;

   always_comb begin
      prod_s  = (sign_a ^ sign_b) ? ({(2*WIDTH){1'b0}} - {hi, lo}) : {hi, lo};
      quo_s   = b_zero ? '1 : ((sign_a ^ sign_b) ? ({WIDTH{1'b0}} - lo) : lo);
      rem_s   = sign_a ? ({WIDTH{1'b0}} - hi) : hi;
      fix_val = '0;
      if (f3[2])
         fix_val = f3[1] ? rem_s : quo_s;
      else if (f3[1:0] == 2'b00)
         fix_val = prod_s[WIDTH-1:0];
      else
         fix_val = prod_s[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         f3     <= '0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         b_zero <= 1'b0;
         hi     <= '0;
         lo     <= '0;
         bmag   <= '0;
         result <= '0;
      end else if (bus.flush && state != IDLE) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               f3     <= bus.funct3;
               sign_a <= neg_a_in;
               sign_b <= neg_b_in;
               b_zero <= (bus.op_b == '0);
               bmag   <= b_mag_in;
`ifdef MULDIV_FASTPATH_EN
               if (trivial) begin
                  hi    <= triv_hi;
                  lo    <= triv_lo;
                  cnt   <= '0;
                  state <= FIX;
               end else begin
                  hi    <= '0;
                  lo    <= a_mag_in;
                  cnt   <= CNT_W'(WIDTH);
                  state <= CALC;
               end
`else
               hi    <= '0;
               lo    <= a_mag_in;
               cnt   <= CNT_W'(WIDTH);
               state <= CALC;
`endif
            end
            CALC: begin
               if (f3[2]) begin
                  hi <= div_ge ? div_sub : div_shift[WIDTH-1:0];
                  lo <= {lo[WIDTH-2:0], div_ge};
               end else if (lo[0]) begin
                  {hi, lo} <= {mul_sum, lo[WIDTH-1:1]};
               end else begin
                  {hi, lo} <= {1'b0, hi, lo[WIDTH-1:1]};
               end
               cnt <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) state <= FIX;
            end
            FIX: begin
               result <= fix_val;
               state  <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy   = (state != IDLE);
   assign bus.done   = (state == DONE);
   assign bus.stall  = bus.busy | accept;
   assign bus.result = result;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed table, random ops vs. arithmetic model, corner sequences.
module tb_muldiv_sequencer;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   muldiv_sequencer_if #(.WIDTH(W)) bus();
   muldiv_sequencer #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int errors = 0;
   int checks = 0;
   logic [31:0] last_exp = '0;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      string       name;
   } vec_t;
   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, ua, ub, p;
      logic [31:0] r;
      logic ovf;
      sa  = {{32{a[31]}}, a};
      sb  = {{32{b[31]}}, b};
      ua  = {32'b0, a};
      ub  = {32'b0, b};
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      p   = '0;
      r   = '0;
      case (f3)
         3'd0: begin p = sa * sb; r = p[31:0];  end
         3'd1: begin p = sa * sb; r = p[63:32]; end
         3'd2: begin p = sa * ub; r = p[63:32]; end
         3'd3: begin p = ua * ub; r = p[63:32]; end
         3'd4: r = (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
         3'd5: r = (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
         3'd6: r = (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
         default: r = (b == 0) ? a : 32'(ua % ub);
      endcase
      return r;
   endfunction

   function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic triv;
      int   fast;
      fast = 0;
`ifdef MULDIV_FASTPATH_EN
      fast = 1;
`endif
      if (f3[2])
         triv = (b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
      else
         triv = (a == 0) || (b == 0);
      return (fast == 1 && triv) ? 2 : W + 2;
   endfunction

   // One full operation from an idle sequencer; n counts samples after the accepting edge.
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string name);
      int n;
      int busy_low;
      @(negedge clk);
      bus.funct3 = f3;
      bus.op_a   = a;
      bus.op_b   = b;
      bus.start  = 1'b1;
      #1;
      check({name, "_stall_req"}, 32'(bus.stall), 32'd1);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.op_a  = $urandom;
      bus.op_b  = $urandom;
      bus.funct3 = 3'($urandom_range(0, 7));
      n = 1;
      busy_low = 0;
      while (bus.done !== 1'b1 && n < 100) begin
         if (bus.busy !== 1'b1) busy_low++;
         @(posedge clk);
         #1;
         n++;
      end
      check({name, "_done_seen"}, 32'(bus.done), 32'd1);
      check({name, "_latency"}, 32'(n), 32'(exp_lat(f3, a, b)));
      check({name, "_busy_gaps"}, 32'(busy_low), 32'd0);
      check({name, "_result"}, bus.result, exp);
      last_exp = exp;
      @(posedge clk);
      #1;
      check({name, "_idle_after"}, {30'd0, bus.busy, bus.done}, 32'd0);
   endtask

   initial begin
      int n;
      int dones;
      logic [2:0]  f3;
      logic [31:0] a, b;
      int sel;

      bus.start  = 1'b0;
      bus.flush  = 1'b0;
      bus.funct3 = '0;
      bus.op_a   = '0;
      bus.op_b   = '0;

      vecs.push_back('{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_neg"});
      vecs.push_back('{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min"});
      vecs.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max"});
      vecs.push_back('{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, "mulhsu_neg"});
      vecs.push_back('{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, "div_neg"});
      vecs.push_back('{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, "rem_neg"});
      vecs.push_back('{3'b101, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, "divu_zero"});
      vecs.push_back('{3'b111, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, "remu_zero"});
      vecs.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf"});
      vecs.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf"});
      vecs.push_back('{3'b101, 32'h0000_0009, 32'h0000_0000, 32'hFFFF_FFFF, "divu9_zero"});
      vecs.push_back('{3'b000, 32'h0000_0000, 32'h0000_1234, 32'h0000_0000, "mul_zero"});
      vecs.push_back('{3'b100, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, "div_min_zero"});
      vecs.push_back('{3'b110, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, "rem_min_zero"});

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_busy",   32'(bus.busy),  32'd0);
      check("rst_done",   32'(bus.done),  32'd0);
      check("rst_stall",  32'(bus.stall), 32'd0);
      check("rst_result", bus.result,     32'd0);
      rst_n = 1'b1;

      foreach (vecs[i]) run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);

      for (int k = 0; k < 60; k++) begin
         f3  = 3'($urandom_range(0, 7));
         a   = $urandom;
         b   = $urandom;
         sel = $urandom_range(0, 15);
         if (sel == 0) b = '0;
         else if (sel == 1) a = '0;
         else if (sel == 2) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         else if (sel == 3) b = 32'($urandom_range(1, 9));
         run_op(f3, a, b, ref_model(f3, a, b), "rand");
      end

      // Flush on the 10th CALC cycle: no done, result untouched
      @(negedge clk);
      bus.funct3 = 3'b000; bus.op_a = 32'd3; bus.op_b = 32'd5; bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      n = 1;
      while (n < 10) begin @(posedge clk); #1; n++; end
      check("flush_busy_before", 32'(bus.busy), 32'd1);
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      check("flush_busy_drop", 32'(bus.busy), 32'd0);
      dones = 0;
      for (int c = 0; c < 40; c++) begin
         if (bus.done === 1'b1) dones++;
         @(posedge clk);
         #1;
      end
      check("flush_no_done", 32'(dones), 32'd0);
      check("flush_result_kept", bus.result, last_exp);

      // start pulsed while busy is ignored
      @(negedge clk);
      bus.funct3 = 3'b000; bus.op_a = 32'd3; bus.op_b = 32'd5; bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      bus.funct3 = 3'b101; bus.op_a = 32'd100; bus.op_b = 32'd7; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      dones = 0;
      for (int c = 0; c < 80; c++) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) dones++;
      end
      check("busy_start_one_done", 32'(dones), 32'd1);
      check("busy_start_result", bus.result, 32'd15);

      // flush and start together in IDLE
      @(negedge clk);
      bus.funct3 = 3'b000; bus.op_a = 32'd2; bus.op_b = 32'd2;
      bus.start = 1'b1; bus.flush = 1'b1;
      #1;
      check("flush_start_stall", 32'(bus.stall), 32'd0);
      @(posedge clk);
      #1;
      bus.start = 1'b0; bus.flush = 1'b0;
      check("flush_start_idle", 32'(bus.busy), 32'd0);

      // Reset mid-operation
      @(negedge clk);
      bus.funct3 = 3'b101; bus.op_a = 32'd1000; bus.op_b = 32'd3; bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_busy",   32'(bus.busy), 32'd0);
      check("midrst_done",   32'(bus.done), 32'd0);
      check("midrst_result", bus.result,    32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(3'b101, 32'd1000, 32'd3, 32'd333, "after_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
